// File: rtl/rc_drive_mixer_if.sv
// -----------------------------------------------------------------------------
// rc_drive_mixer_if
// Purpose : Groups the RC-capture-to-mixer inputs and the mixer-to-PWM outputs
//           into one bundle.
// Signals : ch_throttle   [WIDTH]  throttle pulse length, unsigned
//           ch_steer      [WIDTH]  steering pulse length, unsigned
//           direct_active          RC link alive
//           motor_left    [OUT_W]  signed left motor command
//           motor_right   [OUT_W]  signed right motor command
//           out_stb                one-cycle strobe on a motor output update
//           state         [2]      0=IDLE, 1=ARMING, 2=RUN
// Modports: master - RC capture side (drives channels, observes motors)
//           slave  - the mixer itself
// -----------------------------------------------------------------------------
interface rc_drive_mixer_if #(
    parameter int WIDTH = 17,
    parameter int OUT_W = 10
) ();
    logic        [WIDTH-1:0] ch_throttle;
    logic        [WIDTH-1:0] ch_steer;
    logic                    direct_active;
    logic signed [OUT_W-1:0] motor_left;
    logic signed [OUT_W-1:0] motor_right;
    logic                    out_stb;
    logic        [1:0]       state;

    modport master (
        output ch_throttle, ch_steer, direct_active,
        input  motor_left, motor_right, out_stb, state
    );

    modport slave (
        input  ch_throttle, ch_steer, direct_active,
        output motor_left, motor_right, out_stb, state
    );
endinterface

// File: rtl/rc_drive_mixer.sv
// -----------------------------------------------------------------------------
// rc_drive_mixer
// Purpose : Turns throttle/steering pulse widths into signed left/right motor
//           commands: deadband, clamp, tank mixing, arming, failsafe stop and
//           an optional slew limiter.
// Ports   : clk     - system clock
//           rst_n   - asynchronous active-low reset
//           io_mix  - rc_drive_mixer_if.slave (channels, link flag, motor
//                     outputs, update strobe, FSM state)
// Macro   : RC_RAMP_EN - when defined, outputs in RUN slew toward their target
//           by at most RAMP_STEP per ramp tick. When undefined, outputs follow
//           the mixed target every cycle and RAMP_STEP does not exist.
// Notes   : RAMP_DIV must be >= 2. Latency from channel input to output in the
//           direct (non-ramped) build is 3 cycles: channel register, shaped
//           value register, output register (the mix itself is combinational).
// -----------------------------------------------------------------------------
module rc_drive_mixer #(
    parameter int WIDTH     = 17,
    parameter int CENTER    = 1500,
    parameter int DEADBAND  = 20,
    parameter int OUT_W     = 10,
    parameter int RAMP_DIV  = 50000,
`ifdef RC_RAMP_EN
    parameter int RAMP_STEP = 4,
`endif
    parameter int ARM_TICKS = 100
) (
    input logic             clk,
    input logic             rst_n,
    rc_drive_mixer_if.slave io_mix
);
    localparam int LIMIT  = 2**(OUT_W-1) - 1;
    localparam int TICK_W = $clog2(RAMP_DIV);
    localparam int ARM_W  = $clog2(ARM_TICKS + 1);

    localparam logic signed [WIDTH:0] C_CENTER = (WIDTH+1)'(CENTER);
    localparam logic signed [WIDTH:0] C_DB     = (WIDTH+1)'(DEADBAND);
    localparam logic signed [WIDTH:0] C_LIM_IN = (WIDTH+1)'(LIMIT);
    localparam logic signed [OUT_W:0] C_LIM    = (OUT_W+1)'(LIMIT);
`ifdef RC_RAMP_EN
    localparam logic signed [OUT_W:0] C_STEP   = (OUT_W+1)'(RAMP_STEP);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Centre, deadband and clamp one channel into a signed stick value.
    function automatic logic signed [OUT_W-1:0] shape(input logic [WIDTH-1:0] ch);
        logic signed [WIDTH:0] d;
        logic signed [WIDTH:0] v;
        d = $signed({1'b0, ch}) - C_CENTER;
        if (d > C_DB)
            v = d - C_DB;
        else if (d < -C_DB)
            v = d + C_DB;
        else
            v = '0;
        if (v > C_LIM_IN)
            v = C_LIM_IN;
        else if (v < -C_LIM_IN)
            v = -C_LIM_IN;
        return v[OUT_W-1:0];
    endfunction

    // Symmetric saturation: -LIMIT-1 is never produced.
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [OUT_W:0] s);
        logic signed [OUT_W:0] r;
        if (s > C_LIM)
            r = C_LIM;
        else if (s < -C_LIM)
            r = -C_LIM;
        else
            r = s;
        return r[OUT_W-1:0];
    endfunction

`ifdef RC_RAMP_EN
    // Move cur toward tgt by at most RAMP_STEP; both operands are within
    // +/-LIMIT so the extended result always fits back into OUT_W bits.
    function automatic logic signed [OUT_W-1:0] ramp(input logic signed [OUT_W-1:0] cur,
                                                      input logic signed [OUT_W-1:0] tgt);
        logic signed [OUT_W:0] c_x;
        logic signed [OUT_W:0] t_x;
        logic signed [OUT_W:0] nxt;
        c_x = $signed({cur[OUT_W-1], cur});
        t_x = $signed({tgt[OUT_W-1], tgt});
        if (t_x - c_x > C_STEP)
            nxt = c_x + C_STEP;
        else if (t_x - c_x < -C_STEP)
            nxt = c_x - C_STEP;
        else
            nxt = t_x;
        return nxt[OUT_W-1:0];
    endfunction
`endif

    logic        [TICK_W-1:0] r_tick_cnt;
    logic        [ARM_W-1:0]  r_arm_cnt;
    logic        [WIDTH-1:0]  r_thr;
    logic        [WIDTH-1:0]  r_str;
    logic signed [OUT_W-1:0]  r_vt;
    logic signed [OUT_W-1:0]  r_vs;
    logic                     r_neutral;
    state_e                   r_state;
    logic signed [OUT_W-1:0]  r_left;
    logic signed [OUT_W-1:0]  r_right;
    logic                     r_stb;

    logic                     w_tick;
    logic signed [OUT_W:0]    w_sum;
    logic signed [OUT_W:0]    w_dif;
    logic signed [OUT_W-1:0]  w_tl;
    logic signed [OUT_W-1:0]  w_tr;
    state_e                   w_state_nxt;
    logic signed [OUT_W-1:0]  w_left_nxt;
    logic signed [OUT_W-1:0]  w_right_nxt;
    logic                     w_stb_nxt;

    assign w_tick = (r_tick_cnt == TICK_W'(RAMP_DIV - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of the others regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // NOTE: pipeline registers are reset too (channels to stick neutral) so the
    // neutral flag is meaningful from the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr     <= WIDTH'(CENTER);
            r_str     <= WIDTH'(CENTER);
            r_vt      <= '0;
            r_vs      <= '0;
            r_neutral <= 1'b1;
        end else begin
            r_thr     <= io_mix.ch_throttle;
            r_str     <= io_mix.ch_steer;
            r_vt      <= shape(r_thr);
            r_vs      <= shape(r_str);
            r_neutral <= (shape(r_thr) == '0) && (shape(r_str) == '0);
        end
    end

    // Tank mix is combinational so the direct build keeps a 3-cycle latency.
    assign w_sum = $signed({r_vt[OUT_W-1], r_vt}) + $signed({r_vs[OUT_W-1], r_vs});
    assign w_dif = $signed({r_vt[OUT_W-1], r_vt}) - $signed({r_vs[OUT_W-1], r_vs});
    assign w_tl  = sat(w_sum);
    assign w_tr  = sat(w_dif);

    // Arm counter only runs in ARMING; a non-neutral tick restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_arm_cnt <= '0;
        else if (r_state != ST_ARMING)
            r_arm_cnt <= '0;
        else if (w_tick)
            r_arm_cnt <= r_neutral ? r_arm_cnt + 1'b1 : '0;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state. Losing the link overrides everything, including a tick.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (io_mix.direct_active) w_state_nxt = ST_ARMING;
            ST_ARMING: if (w_tick && r_neutral && (r_arm_cnt == ARM_W'(ARM_TICKS - 1)))
                           w_state_nxt = ST_RUN;
            ST_RUN:    w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (!io_mix.direct_active)
            w_state_nxt = ST_IDLE;
    end

    // FSM: outputs. Anything other than a live RUN forces zero immediately.
    always_comb begin
        w_left_nxt  = '0;
        w_right_nxt = '0;
        w_stb_nxt   = 1'b0;
        if (io_mix.direct_active && (r_state == ST_RUN)) begin
`ifdef RC_RAMP_EN
            w_left_nxt  = r_left;
            w_right_nxt = r_right;
            if (w_tick) begin
                w_left_nxt  = ramp(r_left, w_tl);
                w_right_nxt = ramp(r_right, w_tr);
                w_stb_nxt   = 1'b1;
            end
`else
            w_left_nxt  = w_tl;
            w_right_nxt = w_tr;
`endif
        end
        if ((w_left_nxt != r_left) || (w_right_nxt != r_right))
            w_stb_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left  <= '0;
            r_right <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
            r_stb   <= w_stb_nxt;
        end
    end

    assign io_mix.motor_left  = r_left;
    assign io_mix.motor_right = r_right;
    assign io_mix.out_stb     = r_stb;
    assign io_mix.state       = r_state;

endmodule

// File: tb/tb_rc_drive_mixer.sv
// -----------------------------------------------------------------------------
// tb_rc_drive_mixer
// Purpose : Directed self-checking bench for rc_drive_mixer. Uses a short ramp
//           divider so arming and slewing finish quickly. Expected values are
//           hand-computed; the ramped and direct builds (RC_RAMP_EN) each get
//           their own expectation sequence.
// -----------------------------------------------------------------------------
module tb_rc_drive_mixer;
    localparam int TB_DIV = 8;

    logic clk;
    logic rst_n;
    int   tb_cnt;
    int   n_checks;
    int   n_fail;

    rc_drive_mixer_if #(.WIDTH(17), .OUT_W(10)) mix_if ();

    rc_drive_mixer #(
        .WIDTH    (17),
        .CENTER   (1500),
        .DEADBAND (20),
        .OUT_W    (10),
        .RAMP_DIV (TB_DIV),
        .ARM_TICKS(100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_mix(mix_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model of the ramp tick position: a tick edge is the rising
    // edge seen while the count sits at TB_DIV-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tb_cnt <= 0;
        else
            tb_cnt <= (tb_cnt == TB_DIV - 1) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int exp_l, input int exp_r);
        check({tag, "_L"}, int'($signed(mix_if.motor_left)), exp_l);
        check({tag, "_R"}, int'($signed(mix_if.motor_right)), exp_r);
    endtask

    // Called at a falling edge; returns at the falling edge after n tick edges.
    task automatic advance_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            if (tb_cnt == TB_DIV - 1)
                k++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        mix_if.ch_throttle   = 17'd1500;
        mix_if.ch_steer      = 17'd1500;
        mix_if.direct_active = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", int'(mix_if.state), 0);
        check_out("rst_out", 0, 0);
        check("rst_stb", int'(mix_if.out_stb), 0);

        // Release with link down: stays IDLE
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hold", int'(mix_if.state), 0);

        // Arming with a one-tick disturbance at tick 50
        mix_if.ch_throttle   = 17'd1510;
        mix_if.direct_active = 1'b1;
        @(negedge clk);
        check("arm_enter", int'(mix_if.state), 1);
        advance_ticks(50);
        check("arm_mid", int'(mix_if.state), 1);
        mix_if.ch_throttle = 17'd1600;
        advance_ticks(1);
        mix_if.ch_throttle = 17'd1510;
        advance_ticks(99);
        check("arm_restart_hold", int'(mix_if.state), 1);
        check_out("arm_out", 0, 0);
        advance_ticks(1);
        check("arm_run", int'(mix_if.state), 2);

`ifdef RC_RAMP_EN
        // Mix + ramp: targets L=360, R=200
        mix_if.ch_throttle = 17'd1800;
        mix_if.ch_steer    = 17'd1600;
        advance_ticks(1);
        check_out("ramp_t1", 4, 4);
        check("ramp_t1_stb", int'(mix_if.out_stb), 1);
        @(negedge clk);
        check("ramp_stb_low", int'(mix_if.out_stb), 0);
        advance_ticks(48);
        check_out("ramp_t49", 196, 196);
        advance_ticks(1);
        check_out("ramp_t50", 200, 200);
        advance_ticks(40);
        check_out("ramp_t90", 360, 200);
        check("ramp_t90_stb", int'(mix_if.out_stb), 1);

        // Clamp: L=511, R=0
        mix_if.ch_throttle = 17'd2100;
        mix_if.ch_steer    = 17'd2100;
        advance_ticks(37);
        check_out("clamp_a_t37", 508, 52);
        advance_ticks(13);
        check_out("clamp_a", 511, 0);
        // Clamp: L=0, R=-511
        mix_if.ch_throttle = 17'd900;
        advance_ticks(127);
        check_out("clamp_b_t127", 3, -508);
        advance_ticks(1);
        check_out("clamp_b", 0, -511);

        // Back to L=360, R=200
        mix_if.ch_throttle = 17'd1800;
        mix_if.ch_steer    = 17'd1600;
        advance_ticks(177);
        check_out("fs_pre_t177", 360, 197);
        advance_ticks(1);
        check_out("fs_pre", 360, 200);
`else
        // Direct build: 3-cycle latency, L=R=280
        mix_if.ch_throttle = 17'd1800;
        repeat (2) @(negedge clk);
        check_out("direct_lat2", 0, 0);
        @(negedge clk);
        check_out("direct_lat3", 280, 280);
        check("direct_stb", int'(mix_if.out_stb), 1);
        @(negedge clk);
        check("direct_stb_low", int'(mix_if.out_stb), 0);
        check_out("direct_hold", 280, 280);
        mix_if.ch_steer = 17'd1600;
        repeat (3) @(negedge clk);
        check_out("direct_mix", 360, 200);

        // Clamp
        mix_if.ch_throttle = 17'd2100;
        mix_if.ch_steer    = 17'd2100;
        repeat (3) @(negedge clk);
        check_out("clamp_a", 511, 0);
        mix_if.ch_throttle = 17'd900;
        repeat (3) @(negedge clk);
        check_out("clamp_b", 0, -511);

        mix_if.ch_throttle = 17'd1800;
        mix_if.ch_steer    = 17'd1600;
        repeat (3) @(negedge clk);
        check_out("fs_pre", 360, 200);
`endif

        // Failsafe, dropped on a tick cycle
        while (tb_cnt != TB_DIV - 1)
            @(negedge clk);
        mix_if.direct_active = 1'b0;
        @(negedge clk);
        check_out("fs_out", 0, 0);
        check("fs_state", int'(mix_if.state), 0);
        check("fs_stb", int'(mix_if.out_stb), 1);
        @(negedge clk);
        check("fs_stb_low", int'(mix_if.out_stb), 0);

        // Re-arm needs the full neutral period again
        mix_if.ch_throttle = 17'd1500;
        mix_if.ch_steer    = 17'd1500;
        repeat (3) @(negedge clk);
        if (tb_cnt == TB_DIV - 1)
            @(negedge clk);
        mix_if.direct_active = 1'b1;
        @(negedge clk);
        check("rearm_enter", int'(mix_if.state), 1);
        advance_ticks(99);
        check("rearm_hold", int'(mix_if.state), 1);
        advance_ticks(1);
        check("rearm_run", int'(mix_if.state), 2);

        // Drive to 200/200 then reset asynchronously mid-cycle
        mix_if.ch_throttle = 17'd1720;
`ifdef RC_RAMP_EN
        advance_ticks(50);
`else
        repeat (3) @(negedge clk);
`endif
        check_out("prerst", 200, 200);
        #2;
        rst_n = 1'b0;
        mix_if.direct_active = 1'b0;
        #1;
        check_out("async_rst", 0, 0);
        check("async_rst_state", int'(mix_if.state), 0);
        check("async_rst_stb", int'(mix_if.out_stb), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", int'(mix_if.state), 0);
        check_out("post_rst_out", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rc_drive_mixer.md
Name: rc_drive_mixer

Overview:
Consumes the direct RC channel pulse widths (throttle, steering) and the direct-active flag from the RC capture block. Converts them into signed left/right motor speed commands using deadband, clamping and differential (tank) mixing. Applies arming and failsafe sequencing and a slew-rate limiter. Output feeds the motor PWM drivers.

Parameters:
WIDTH, 17, width of incoming pulse-length values
CENTER, 1500, pulse length of stick neutral
DEADBAND, 20, half-width of neutral zone around CENTER
OUT_W, 10, width of signed motor outputs; LIMIT = 2^(OUT_W-1)-1 (511)
RAMP_DIV, 50000, clk cycles per ramp tick (1 ms at 50 MHz)
RAMP_STEP, 4, maximum output change per ramp tick
ARM_TICKS, 100, consecutive neutral ramp ticks required to arm

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ch_throttle  input  WIDTH  throttle pulse length, unsigned, held between updates
ch_steer  input  WIDTH  steering pulse length, unsigned
direct_active  input  1  RC link alive
motor_left  output  OUT_W  signed left motor command
motor_right  output  OUT_W  signed right motor command
out_stb  output  1  one-cycle strobe when motor outputs are updated
state  output  2  0=IDLE, 1=ARMING, 2=RUN

Behaviour:
- Reset (async assert, sync release): motor_left = 0, motor_right = 0, out_stb = 0, state = IDLE, tick counter = 0, arm counter = 0.
- Tick counter:
  - Free-running 0..RAMP_DIV-1.
  - tick is asserted for 1 cycle when the count equals RAMP_DIV-1; the counter then wraps to 0.
- Pipeline (3 cycles from an input change to target valid):
  - S0: register both channel inputs.
  - S1: d = ch - CENTER, signed WIDTH+1.
    - If |d| <= DEADBAND, v = 0; otherwise v = d - sign(d)*DEADBAND.
    - Clamp v to ±LIMIT.
    - neutral = both v == 0.
  - S2: tl = vt + vs, tr = vt - vs, computed at OUT_W+1 bits, each clamped to ±LIMIT.
- FSM:
  - IDLE: outputs forced to 0. Enter ARMING when direct_active = 1; arm counter cleared.
  - ARMING: outputs remain 0.
    - On each tick: if neutral, arm counter increments; otherwise it is cleared.
    - When the arm counter reaches ARM_TICKS, go to RUN.
  - RUN: on each tick, each output moves toward its target by min(|target - out|, RAMP_STEP). out_stb is asserted on that cycle.
  - Any state with direct_active = 0: next cycle goes to IDLE with both outputs = 0. This is an immediate stop with no ramp, and out_stb pulses if the outputs were nonzero.
- Simultaneous events:
  - direct_active falling on a tick cycle: failsafe wins.
  - Arm counter reaching ARM_TICKS on the same tick as non-neutral input: counter clears, no arm.
- Output is never outside ±LIMIT. -LIMIT-1 is never produced.

Optional Feature:
- Macro RC_RAMP_EN.
- Defined: slew limiter as described.
- Undefined: in RUN, outputs load tl/tr every cycle (3-cycle latency from input change). out_stb pulses on any cycle where either output changes. The ramp step logic is removed; the tick counter stays for arming.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN with outputs at 200 -> outputs 0 and state IDLE immediately (async); after release, state stays IDLE while direct_active = 0.
- Arming: direct_active = 1, throttle = 1510, steer = 1500 -> ARMING, then RUN after 100 ticks. Throttle at 1600 for one tick at tick 50 -> counter restarts, and RUN is reached only 100 neutral ticks later.
- Mix + ramp: RUN, throttle = 1800, steer = 1600 -> targets L = 360, R = 200. Outputs step +4 per tick; R = 200 after 50 ticks, L = 360 after 90 ticks; out_stb once per tick.
- Clamp: throttle = 2100, steer = 2100 -> vt = vs = 511; targets L = 511, R = 0. Throttle = 900, steer = 2100 -> L = 0, R = -511.
- Failsafe: RUN with L = 360, R = 200; drop direct_active -> next cycle L = R = 0, state IDLE; re-raise -> ARMING, full 100-tick neutral requirement again.
- RC_RAMP_EN undefined: RUN, throttle stepped 1500 -> 1800 -> motor_left = motor_right = 280 exactly 3 cycles later, out_stb for 1 cycle.
